// File: rtl/param_ram_pkg.sv
// Shared types and default sizing for the param_ram block.
package param_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 10;

endpackage

// File: rtl/param_ram_core.sv
// Storage array for param_ram: one write port, one registered read port.
// The read register can be loaded from an override value instead of the array.
module param_ram_core
    import param_ram_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    input  logic             rd_force_i,
    input  logic [WIDTH-1:0] rd_force_data_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Contents are established by the clear sweep, so the array carries no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_force_i ? rd_force_data_i : mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/param_ram.sv
// Parameterised RAM with clear sweep FSM, range checking and error pulses.
// Define PARAM_RAM_BYPASS_EN for write-through on same-address read/write.
module param_ram
    import param_ram_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             re,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             err_wr,
    output logic             err_rd
);

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t          state_q;
    logic [AW-1:0]   ptr_q;
    logic            rd_valid_q;
    logic            err_wr_q;
    logic            err_rd_q;

    logic            idle;
    logic            wr_in_range;
    logic            rd_in_range;
    logic            wr_ok;
    logic            rd_ok;
    logic            bypass;
    logic            core_we;
    logic [AW-1:0]   core_waddr;
    logic [WIDTH-1:0] core_wdata;
    logic            rd_force;
    logic [WIDTH-1:0] rd_force_data;

    assign idle        = (state_q == IDLE);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_ok       = idle && we && wr_in_range;
    assign rd_ok       = idle && re;

`ifdef PARAM_RAM_BYPASS_EN
    assign bypass = wr_ok && (wr_addr == rd_addr);
`else
    assign bypass = 1'b0;
`endif

    // The sweep owns the write port while clearing; user writes only in IDLE.
    assign core_we       = idle ? wr_ok : 1'b1;
    assign core_waddr    = idle ? wr_addr : ptr_q;
    assign core_wdata    = idle ? wr_data : '0;
    assign rd_force      = !rd_in_range || bypass;
    assign rd_force_data = rd_in_range ? wr_data : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= CLEAR;
            ptr_q      <= '0;
            rd_valid_q <= 1'b0;
            err_wr_q   <= 1'b0;
            err_rd_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
            err_rd_q   <= rd_ok && !rd_in_range;
            err_wr_q   <= idle && we && !wr_in_range;
            unique case (state_q)
                IDLE: begin
                    if (clear) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                    end
                end
                CLEAR: begin
                    if (clear) begin
                        ptr_q <= '0;
                    end else if (ptr_q == LAST) begin
                        state_q <= IDLE;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    param_ram_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_core (
        .clk_i           (clock),
        .rst_ni          (reset),
        .wr_en_i         (core_we),
        .wr_addr_i       (core_waddr),
        .wr_data_i       (core_wdata),
        .rd_en_i         (rd_ok),
        .rd_addr_i       (rd_addr),
        .rd_force_i      (rd_force),
        .rd_force_data_i (rd_force_data),
        .rd_data_o       (rd_data)
    );

    assign rd_valid = rd_valid_q;
    assign busy     = (state_q == CLEAR);
    assign err_wr   = err_wr_q;
    assign err_rd   = err_rd_q;

endmodule

// File: tb/tb_param_ram.sv
// Self-checking bench for param_ram: behavioural model plus directed literal checks.
module tb_param_ram;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 10;
    localparam int unsigned AW    = 4;
`ifdef PARAM_RAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             clear = 1'b0;
    logic             we = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             re = 1'b0;
    logic [AW-1:0]    rd_addr = '0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             busy;
    logic             err_wr;
    logic             err_rd;

    int pass_cnt  = 0;
    int total_cnt = 0;

    param_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .re       (re),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .err_wr   (err_wr),
        .err_rd   (err_rd)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Model: the array as plain words and the clear sweep as a count of busy cycles left.
    logic [WIDTH-1:0] mem_m [DEPTH];
    int               rem_m   = DEPTH;
    logic [WIDTH-1:0] exp_rd  = '0;
    logic             exp_val = 1'b0;
    logic             exp_ew  = 1'b0;
    logic             exp_er  = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_m   = DEPTH;
            exp_rd  = '0;
            exp_val = 1'b0;
            exp_ew  = 1'b0;
            exp_er  = 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end else begin
            automatic bit free = (rem_m == 0);
            automatic bit rd_in = int'(rd_addr) < DEPTH;
            automatic bit wr_in = int'(wr_addr) < DEPTH;
            exp_val = free && re;
            exp_er  = free && re && !rd_in;
            exp_ew  = free && we && !wr_in;
            if (free && re) begin
                if (!rd_in) exp_rd = '0;
                else if (BYP && we && wr_in && wr_addr == rd_addr) exp_rd = wr_data;
                else exp_rd = mem_m[rd_addr];
            end
            if (free && we && wr_in) mem_m[wr_addr] = wr_data;
            if (clear) begin
                rem_m = DEPTH;
                for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            end else if (!free) begin
                rem_m = rem_m - 1;
            end
        end
    end

    always @(negedge clock) begin
        if ($time > 1) begin
            chk("m_busy",     64'(busy),     64'(rem_m != 0));
            chk("m_rd_valid", 64'(rd_valid), 64'(exp_val));
            chk("m_rd_data",  64'(rd_data),  64'(exp_rd));
            chk("m_err_wr",   64'(err_wr),   64'(exp_ew));
            chk("m_err_rd",   64'(err_rd),   64'(exp_er));
        end
    end

    task automatic wr(input int a, input int d);
        we = 1'b1; wr_addr = AW'(a); wr_data = WIDTH'(d);
        @(negedge clock);
        we = 1'b0;
    endtask

    task automatic rd(input int a);
        re = 1'b1; rd_addr = AW'(a);
        @(negedge clock);
        re = 1'b0;
    endtask

    task automatic count_busy(input string name, input int exp_n);
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk(name, 64'(n), 64'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_busy",     64'(busy), 64'd1);
        chk("rst_rd_data",  64'(rd_data), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        count_busy("sweep_after_reset", 10);

        rd(3);
        chk("rd3_data",  64'(rd_data), 64'h0000);
        chk("rd3_valid", 64'(rd_valid), 64'd1);

        wr(9, 'hBEEF);
        rd(9);
        chk("rd9_data", 64'(rd_data), 64'hBEEF);

        wr(12, 'h7777);
        chk("err_wr_pulse", 64'(err_wr), 64'd1);
        rd(12);
        chk("err_rd_pulse", 64'(err_rd), 64'd1);
        chk("rd12_data",    64'(rd_data), 64'h0000);
        chk("rd12_valid",   64'(rd_valid), 64'd1);
        chk("err_wr_gone",  64'(err_wr), 64'd0);
        rd(9);
        chk("rd9_kept", 64'(rd_data), 64'hBEEF);
        chk("err_rd_gone", 64'(err_rd), 64'd0);

        wr(5, 'hAAAA);
        we = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
        re = 1'b1; rd_addr = 4'd5;
        @(negedge clock);
        we = 1'b0; re = 1'b0;
        chk("same_addr", 64'(rd_data), BYP ? 64'h1234 : 64'hAAAA);
        rd(5);
        chk("rd5_new", 64'(rd_data), 64'h1234);

        we = 1'b1; wr_addr = 4'd7; wr_data = 16'h0F0F;
        re = 1'b1; rd_addr = 4'd9;
        @(negedge clock);
        we = 1'b0; re = 1'b0;
        chk("diff_addr", 64'(rd_data), 64'hBEEF);
        rd(7);
        chk("rd7", 64'(rd_data), 64'h0F0F);
        @(negedge clock);
        chk("hold_valid", 64'(rd_valid), 64'd0);
        chk("hold_data",  64'(rd_data), 64'h0F0F);

        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        repeat (3) @(negedge clock);
        we = 1'b1; wr_addr = 4'd4; wr_data = 16'hFFFF; re = 1'b1; rd_addr = 4'd4;
        @(negedge clock);
        we = 1'b0; re = 1'b0;
        chk("busy_no_valid", 64'(rd_valid), 64'd0);
        repeat (2) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        count_busy("sweep_after_restart", 10);
        for (int a = 0; a < DEPTH; a++) begin
            rd(a);
            chk("cleared_word", 64'(rd_data), 64'd0);
        end

        wr(2, 'h5A5A);
        rd(2);
        chk("rd2", 64'(rd_data), 64'h5A5A);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        repeat (4) @(negedge clock);
        chk("mid_sweep_hold", 64'(rd_data), 64'h5A5A);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("async_busy",     64'(busy), 64'd1);
        chk("async_rd_data",  64'(rd_data), 64'd0);
        chk("async_rd_valid", 64'(rd_valid), 64'd0);
        chk("async_err",      64'({err_wr, err_rd}), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        count_busy("sweep_after_abort", 10);
        rd(2);
        chk("rd2_after_abort", 64'(rd_data), 64'd0);

        @(negedge clock);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
